// File: rtl/pcq_ram_seq.sv
// Pervasive-side RAM sequencer: accepts one RAM command, issues it to the IU RAM-insert stage,
// then waits for completion, abort, flush limit or timeout and reports the outcome.
module pcq_ram_seq #(
    parameter int THREADS     = 2,
    parameter int TMO_WIDTH   = 10,
    parameter int TMO_LIMIT   = 1023,
    parameter int FLUSH_WIDTH = 4
) (
    input  logic                   nclk,
    input  logic                   rst_b,
    input  logic                   cmd_val,
    input  logic [31:0]            cmd_instr,
    input  logic [3:0]             cmd_ext,
    input  logic [THREADS-1:0]     cmd_thread,
    input  logic                   cmd_abort,
    output logic                   cmd_ack,
    output logic [31:0]            pc_iu_ram_instr,
    output logic [3:0]             pc_iu_ram_instr_ext,
    output logic                   pc_iu_ram_issue,
    output logic [THREADS-1:0]     pc_iu_ram_active,
    input  logic                   iu_pc_ram_done,
    input  logic [THREADS-1:0]     cp_flush,
    output logic                   ram_busy,
    output logic                   ram_done,
    output logic [1:0]             ram_err,
    output logic [FLUSH_WIDTH-1:0] ram_flush_cnt,
    output logic [1:0]             ram_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_TMO   = 2'b01;
    localparam logic [1:0] ERR_FLUSH = 2'b10;
    localparam logic [1:0] ERR_ABORT = 2'b11;

    localparam logic [FLUSH_WIDTH-1:0] FLUSH_LIMIT = '1;
    localparam logic [TMO_WIDTH-1:0]   TMO_LAST    = TMO_WIDTH'(TMO_LIMIT - 1);

    // Handshake: cmd_ack is a combinational accept, only in IDLE with cmd_val and a one-hot
    // cmd_thread; the command is consumed on the clock edge where cmd_ack is high. A request
    // made while busy is simply not acked and must be retried by the requester.

    logic [1:0]             state;
    logic [THREADS-1:0]     thread_mask;
    logic [TMO_WIDTH-1:0]   tmo_cnt;
    logic                   thread_onehot;
    logic                   flush_hit;
    logic [FLUSH_WIDTH-1:0] flush_inc;
    logic                   wait_exit;
    logic [1:0]             wait_err;

    always_comb begin
        thread_onehot = (cmd_thread != '0) && ((cmd_thread & (cmd_thread - 1'b1)) == '0);
        cmd_ack       = (state == S_IDLE) && cmd_val && thread_onehot;
        flush_hit     = |(cp_flush & thread_mask);
        flush_inc     = (ram_flush_cnt == FLUSH_LIMIT) ? ram_flush_cnt : ram_flush_cnt + 1'b1;
    end

    // WAIT exit priority: IU done > abort > flush limit > timeout.
    always_comb begin
        wait_exit = 1'b1;
        wait_err  = ERR_OK;
        if (iu_pc_ram_done) begin
            wait_err = ERR_OK;
        end else if (cmd_abort) begin
            wait_err = ERR_ABORT;
        end else if (flush_hit && (flush_inc == FLUSH_LIMIT)) begin
            wait_err = ERR_FLUSH;
        end else if (tmo_cnt == TMO_LAST) begin
            wait_err = ERR_TMO;
        end else begin
            wait_exit = 1'b0;
        end
    end

    assign ram_state = state;

    always_ff @(posedge nclk or negedge rst_b) begin
        if (!rst_b) begin
            state               <= S_IDLE;
            thread_mask         <= '0;
            tmo_cnt             <= '0;
            pc_iu_ram_instr     <= '0;
            pc_iu_ram_instr_ext <= '0;
            pc_iu_ram_issue     <= 1'b0;
            pc_iu_ram_active    <= '0;
            ram_busy            <= 1'b0;
            ram_done            <= 1'b0;
            ram_err             <= ERR_OK;
            ram_flush_cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_ack) begin
                        pc_iu_ram_instr     <= cmd_instr;
                        pc_iu_ram_instr_ext <= cmd_ext;
                        thread_mask         <= cmd_thread;
                        ram_err             <= ERR_OK;
                        ram_flush_cnt       <= '0;
                        tmo_cnt             <= '0;
                        pc_iu_ram_issue     <= 1'b1;
                        pc_iu_ram_active    <= cmd_thread;
                        ram_busy            <= 1'b1;
                        state               <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    pc_iu_ram_issue <= 1'b0;
                    if (flush_hit) begin
                        ram_flush_cnt <= flush_inc;
                    end
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (flush_hit) begin
                        ram_flush_cnt <= flush_inc;
                    end
                    if (wait_exit) begin
                        ram_err          <= wait_err;
                        ram_done         <= 1'b1;
                        pc_iu_ram_active <= '0;
                        state            <= S_DONE;
                    end
                end
                default: begin
                    ram_done <= 1'b0;
                    ram_busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcq_ram_seq.sv
// Directed bench for pcq_ram_seq: accept/complete, timeout, flush counting, rejection,
// event priority and asynchronous reset in the middle of an operation.
module tb_pcq_ram_seq;

    localparam int THREADS     = 2;
    localparam int TMO_WIDTH   = 10;
    localparam int TMO_LIMIT   = 16;
    localparam int FLUSH_WIDTH = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic                   nclk;
    logic                   rst_b;
    logic                   cmd_val;
    logic [31:0]            cmd_instr;
    logic [3:0]             cmd_ext;
    logic [THREADS-1:0]     cmd_thread;
    logic                   cmd_abort;
    logic                   cmd_ack;
    logic [31:0]            pc_iu_ram_instr;
    logic [3:0]             pc_iu_ram_instr_ext;
    logic                   pc_iu_ram_issue;
    logic [THREADS-1:0]     pc_iu_ram_active;
    logic                   iu_pc_ram_done;
    logic [THREADS-1:0]     cp_flush;
    logic                   ram_busy;
    logic                   ram_done;
    logic [1:0]             ram_err;
    logic [FLUSH_WIDTH-1:0] ram_flush_cnt;
    logic [1:0]             ram_state;

    int n_checks = 0;
    int n_fail   = 0;

    pcq_ram_seq #(
        .THREADS    (THREADS),
        .TMO_WIDTH  (TMO_WIDTH),
        .TMO_LIMIT  (TMO_LIMIT),
        .FLUSH_WIDTH(FLUSH_WIDTH)
    ) dut (
        .nclk               (nclk),
        .rst_b              (rst_b),
        .cmd_val            (cmd_val),
        .cmd_instr          (cmd_instr),
        .cmd_ext            (cmd_ext),
        .cmd_thread         (cmd_thread),
        .cmd_abort          (cmd_abort),
        .cmd_ack            (cmd_ack),
        .pc_iu_ram_instr    (pc_iu_ram_instr),
        .pc_iu_ram_instr_ext(pc_iu_ram_instr_ext),
        .pc_iu_ram_issue    (pc_iu_ram_issue),
        .pc_iu_ram_active   (pc_iu_ram_active),
        .iu_pc_ram_done     (iu_pc_ram_done),
        .cp_flush           (cp_flush),
        .ram_busy           (ram_busy),
        .ram_done           (ram_done),
        .ram_err            (ram_err),
        .ram_flush_cnt      (ram_flush_cnt),
        .ram_state          (ram_state)
    );

    // Clock / reset
    initial begin
        nclk = 1'b0;
        forever #5 nclk = ~nclk;
    end

    // Drivers: inputs change 1 time unit after the rising edge, outputs are read there too.
    task automatic tick();
        @(posedge nclk);
        #1;
    endtask

    task automatic drive_idle();
        cmd_val        = 1'b0;
        cmd_instr      = '0;
        cmd_ext        = '0;
        cmd_thread     = '0;
        cmd_abort      = 1'b0;
        iu_pc_ram_done = 1'b0;
        cp_flush       = '0;
    endtask

    // Presents a command for one cycle; returns the combinational ack seen before the edge.
    task automatic send_cmd(input logic [31:0] instr, input logic [3:0] ext,
                            input logic [THREADS-1:0] thr, output logic ack);
        cmd_val    = 1'b1;
        cmd_instr  = instr;
        cmd_ext    = ext;
        cmd_thread = thr;
        #1;
        ack = cmd_ack;
        tick();
        cmd_val    = 1'b0;
        cmd_thread = '0;
    endtask

    // Ticks until ram_done is seen or the budget runs out; cyc = edges waited.
    task automatic wait_done(input int max_cyc, output int cyc);
        cyc = 0;
        while (ram_done !== 1'b1 && cyc < max_cyc) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst_b = 1'b0;
        #3;
        n_checks++;
        if ({ram_state, ram_busy, ram_done, ram_err, ram_flush_cnt, pc_iu_ram_issue, pc_iu_ram_active} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: state=%0d busy=%b done=%b err=%b cnt=%0d issue=%b active=%b, all required 0",
                     ram_state, ram_busy, ram_done, ram_err, ram_flush_cnt, pc_iu_ram_issue, pc_iu_ram_active);
        end
        n_checks++;
        if (pc_iu_ram_instr !== 32'h0 || cmd_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_instr_ack: instr=%h ack=%b, required 0/0", pc_iu_ram_instr, cmd_ack);
        end
        tick();
        tick();
        rst_b = 1'b1;
        tick();
    endtask

    task automatic test_accept();
        logic ack;
        int   cyc;
        send_cmd(32'h7C0002A6, 4'h0, 2'b01, ack);
        n_checks++;
        if (ack !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_ack: got %b required 1", ack);
        end
        n_checks++;
        if (ram_state !== S_ISSUE || pc_iu_ram_issue !== 1'b1 || pc_iu_ram_active !== 2'b01 || ram_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_issue: state=%0d issue=%b active=%b busy=%b required 1/1/01/1",
                     ram_state, pc_iu_ram_issue, pc_iu_ram_active, ram_busy);
        end
        n_checks++;
        if (pc_iu_ram_instr !== 32'h7C0002A6 || pc_iu_ram_instr_ext !== 4'h0) begin
            n_fail++;
            $display("FAIL accept_instr: got %h/%h required 7c0002a6/0", pc_iu_ram_instr, pc_iu_ram_instr_ext);
        end
        tick();
        n_checks++;
        if (ram_state !== S_WAIT || pc_iu_ram_issue !== 1'b0 || pc_iu_ram_active !== 2'b01) begin
            n_fail++;
            $display("FAIL accept_wait: state=%0d issue=%b active=%b required 2/0/01",
                     ram_state, pc_iu_ram_issue, pc_iu_ram_active);
        end
        for (int i = 0; i < 4; i++) tick();
        iu_pc_ram_done = 1'b1;
        tick();
        iu_pc_ram_done = 1'b0;
        n_checks++;
        if (ram_done !== 1'b1 || ram_err !== 2'b00 || pc_iu_ram_active !== 2'b00 || ram_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_done: done=%b err=%b active=%b busy=%b required 1/00/00/1",
                     ram_done, ram_err, pc_iu_ram_active, ram_busy);
        end
        tick();
        n_checks++;
        if (ram_state !== S_IDLE || ram_busy !== 1'b0 || ram_done !== 1'b0 || pc_iu_ram_instr !== 32'h7C0002A6) begin
            n_fail++;
            $display("FAIL accept_idle: state=%0d busy=%b done=%b instr=%h required 0/0/0/7c0002a6",
                     ram_state, ram_busy, ram_done, pc_iu_ram_instr);
        end
        cyc = 0;
    endtask

    task automatic test_timeout();
        logic ack;
        int   cyc;
        send_cmd(32'h11112222, 4'h5, 2'b10, ack);
        tick();
        // Now in the first WAIT cycle; DONE is the 17th cycle counting this one as 1.
        wait_done(40, cyc);
        n_checks++;
        if (ram_done !== 1'b1 || cyc !== TMO_LIMIT) begin
            n_fail++;
            $display("FAIL timeout_latency: done=%b after %0d edges, required done=1 after %0d",
                     ram_done, cyc, TMO_LIMIT);
        end
        n_checks++;
        if (ram_err !== 2'b01 || pc_iu_ram_active !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_err: err=%b active=%b required 01/00", ram_err, pc_iu_ram_active);
        end
        tick();
    endtask

    task automatic test_flush_count();
        logic ack;
        int   cyc;
        send_cmd(32'hAAAA0001, 4'h1, 2'b01, ack);
        cp_flush = 2'b01;
        tick();
        cp_flush = 2'b10;
        tick();
        cp_flush = 2'b01;
        tick();
        cp_flush = 2'b10;
        tick();
        cp_flush = 2'b01;
        tick();
        cp_flush = 2'b00;
        iu_pc_ram_done = 1'b1;
        tick();
        iu_pc_ram_done = 1'b0;
        n_checks++;
        if (ram_done !== 1'b1 || ram_flush_cnt !== 4'd3 || ram_err !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_count: done=%b cnt=%0d err=%b required 1/3/00", ram_done, ram_flush_cnt, ram_err);
        end
        tick();
        n_checks++;
        if (ram_flush_cnt !== 4'd3) begin
            n_fail++;
            $display("FAIL flush_persist: cnt=%0d required 3", ram_flush_cnt);
        end
    endtask

    task automatic test_flush_limit();
        logic ack;
        int   cyc;
        send_cmd(32'hAAAA0002, 4'h2, 2'b01, ack);
        cp_flush = 2'b01;
        tick();
        // ISSUE counted 1; the WAIT cycle holding 14 reaches the limit, 14 edges from here.
        wait_done(40, cyc);
        cp_flush = 2'b00;
        n_checks++;
        if (ram_done !== 1'b1 || cyc !== 14 || ram_err !== 2'b10 || ram_flush_cnt !== 4'd15) begin
            n_fail++;
            $display("FAIL flush_limit: done=%b edges=%0d err=%b cnt=%0d required 1/14/10/15",
                     ram_done, cyc, ram_err, ram_flush_cnt);
        end
        tick();
    endtask

    task automatic test_reject();
        logic ack;
        send_cmd(32'hBAD00000, 4'h0, 2'b00, ack);
        n_checks++;
        if (ack !== 1'b0 || ram_state !== S_IDLE || ram_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reject_zero: ack=%b state=%0d busy=%b required 0/0/0", ack, ram_state, ram_busy);
        end
        send_cmd(32'hBAD00011, 4'h0, 2'b11, ack);
        n_checks++;
        if (ack !== 1'b0 || ram_state !== S_IDLE || ram_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reject_multi: ack=%b state=%0d busy=%b required 0/0/0", ack, ram_state, ram_busy);
        end
        send_cmd(32'h12345678, 4'h9, 2'b10, ack);
        send_cmd(32'hDEADBEEF, 4'h3, 2'b01, ack);
        n_checks++;
        if (ack !== 1'b0 || pc_iu_ram_instr !== 32'h12345678 || pc_iu_ram_instr_ext !== 4'h9) begin
            n_fail++;
            $display("FAIL reject_busy: ack=%b instr=%h ext=%h required 0/12345678/9",
                     ack, pc_iu_ram_instr, pc_iu_ram_instr_ext);
        end
        iu_pc_ram_done = 1'b1;
        tick();
        iu_pc_ram_done = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        logic ack;
        send_cmd(32'h00000055, 4'h0, 2'b01, ack);
        tick();
        iu_pc_ram_done = 1'b1;
        cmd_abort      = 1'b1;
        tick();
        iu_pc_ram_done = 1'b0;
        cmd_abort      = 1'b0;
        n_checks++;
        if (ram_done !== 1'b1 || ram_err !== 2'b00) begin
            n_fail++;
            $display("FAIL done_beats_abort: done=%b err=%b required 1/00", ram_done, ram_err);
        end
        tick();
        // Abort during ISSUE is ignored; the one in WAIT ends the op.
        send_cmd(32'h00000066, 4'h0, 2'b10, ack);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        n_checks++;
        if (ram_state !== S_WAIT || ram_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_in_issue: state=%0d done=%b required 2/0", ram_state, ram_done);
        end
        tick();
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        n_checks++;
        if (ram_done !== 1'b1 || ram_err !== 2'b11 || pc_iu_ram_active !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_alone: done=%b err=%b active=%b required 1/11/00", ram_done, ram_err, pc_iu_ram_active);
        end
        tick();
        cmd_abort = 1'b1;
        tick();
        tick();
        cmd_abort = 1'b0;
        n_checks++;
        if (ram_state !== S_IDLE || ram_busy !== 1'b0 || ram_done !== 1'b0 || ram_err !== 2'b11) begin
            n_fail++;
            $display("FAIL abort_in_idle: state=%0d busy=%b done=%b err=%b required 0/0/0/11",
                     ram_state, ram_busy, ram_done, ram_err);
        end
    endtask

    task automatic test_reset_mid_op();
        logic ack;
        send_cmd(32'h0F0F0F0F, 4'hF, 2'b10, ack);
        tick();
        tick();
        rst_b = 1'b0;
        #1;
        n_checks++;
        if (pc_iu_ram_active !== 2'b00 || pc_iu_ram_issue !== 1'b0 || ram_busy !== 1'b0 || ram_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL reset_mid_op: active=%b issue=%b busy=%b state=%0d required 00/0/0/0",
                     pc_iu_ram_active, pc_iu_ram_issue, ram_busy, ram_state);
        end
        tick();
        rst_b = 1'b1;
        tick();
        send_cmd(32'hCAFEF00D, 4'h7, 2'b01, ack);
        n_checks++;
        if (ack !== 1'b1 || pc_iu_ram_issue !== 1'b1 || pc_iu_ram_active !== 2'b01 || pc_iu_ram_instr !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL reset_recover: ack=%b issue=%b active=%b instr=%h required 1/1/01/cafef00d",
                     ack, pc_iu_ram_issue, pc_iu_ram_active, pc_iu_ram_instr);
        end
        tick();
        iu_pc_ram_done = 1'b1;
        tick();
        iu_pc_ram_done = 1'b0;
        n_checks++;
        if (ram_done !== 1'b1 || ram_err !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_recover_done: done=%b err=%b required 1/00", ram_done, ram_err);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_accept();
        test_timeout();
        test_flush_count();
        test_flush_limit();
        test_reject();
        test_simultaneous();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
